// File: rtl/if_inst_queue.sv
`default_nettype none
// ============================================================================
// Module   : if_inst_queue
// Brief    : Fetch-to-decode instruction queue (PC + instruction), flushable.
// Revision : 1.0
// ============================================================================
module if_inst_queue #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 64,
    parameter int INST_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PC_W-1:0]            in_pc,
    input  logic [INST_W-1:0]          in_inst,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PC_W-1:0]            out_pc,
    output logic [INST_W-1:0]          out_inst,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

    logic [PC_W-1:0]   r_mem_pc   [DEPTH];
    logic [INST_W-1:0] r_mem_inst [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_CW-1:0]   r_count;
    logic              w_push;
    logic              w_pop;

    // rst gates in_ready directly: count alone is already 0 during reset and
    // would otherwise advertise space while the queue is held.
    assign in_ready  = !rst && (r_count < c_FULL) && !flush;
    assign out_valid = (r_count != '0) && !flush;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    assign out_pc   = out_valid ? r_mem_pc[r_rd_ptr]   : '0;
    assign out_inst = out_valid ? r_mem_inst[r_rd_ptr] : '0;
    assign count    = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]   <= in_pc;
            r_mem_inst[r_wr_ptr] <= in_inst;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire
